// File: rtl/reset_sequencer.sv
// Purpose: qualify reset release on external reset and PLL lock, then release cold and per-domain resets in order.
// Latency: cold release DEBOUNCE_CYCLES+1 edges after inputs go good, then one domain every STAGE_CYCLES; full reset asserts in 1 cycle.
// Backpressure: none on the sequence; software resets use a level req/ack 4-phase handshake per domain.
module reset_sequencer #(
    parameter int NUM_DOMAINS      = 3,
    parameter int DEBOUNCE_CYCLES  = 256,
    parameter int STAGE_CYCLES     = 16,
    parameter int SOFT_HOLD_CYCLES = 8
) (
    input  logic                   clk_ref,
    input  logic                   por,
    input  logic                   rst_ext_n,
    input  logic                   pll_locked,
    input  logic                   lock_loss_rst_en,
    input  logic [NUM_DOMAINS-1:0] soft_rst_req,
    output logic [NUM_DOMAINS-1:0] soft_rst_ack,
    output logic                   rst_cold_n,
    output logic [NUM_DOMAINS-1:0] rst_dom_n,
    output logic                   rst_done,
    output logic [1:0]             rst_cause,
    output logic                   lock_lost
);

    localparam int MAX_CNT = (DEBOUNCE_CYCLES > STAGE_CYCLES) ? DEBOUNCE_CYCLES : STAGE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT) + 1;
    localparam int HOLD_W  = $clog2(SOFT_HOLD_CYCLES) + 1;
    localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  STG_LAST  = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SOFT_HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

    localparam logic [2:0] ST_ASSERT   = 3'd0;
    localparam logic [2:0] ST_DEBOUNCE = 3'd1;
    localparam logic [2:0] ST_COLD     = 3'd2;
    localparam logic [2:0] ST_STAGE    = 3'd3;
    localparam logic [2:0] ST_COMPLETE = 3'd4;

    localparam logic [1:0] SS_IDLE = 2'd0;
    localparam logic [1:0] SS_HOLD = 2'd1;
    localparam logic [1:0] SS_ACK  = 2'd2;

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_EXT  = 2'b01;
    localparam logic [1:0] CAUSE_LOCK = 2'b10;

    logic [2:0]             state;
    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       idx;
    logic [1:0]             soft_st  [NUM_DOMAINS];
    logic [HOLD_W-1:0]      hold_cnt [NUM_DOMAINS];

    logic                   in_run;
    logic                   ext_hit;
    logic                   lock_hit;
    logic                   full_rst;
    logic                   stage_done;
    logic [NUM_DOMAINS-1:0] stage_rel;

    // Decode full-reset events and which domain (if any) is released this cycle.
    always_comb begin
        in_run     = (state == ST_COLD) || (state == ST_STAGE) || (state == ST_COMPLETE);
        ext_hit    = in_run && !rst_ext_n;
        lock_hit   = in_run && !pll_locked;
        full_rst   = ext_hit || (lock_hit && lock_loss_rst_en);
        stage_done = (state == ST_STAGE) && (cnt == STG_LAST);
        stage_rel  = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (stage_done && (idx == IDX_W'(i))) begin
                stage_rel[i] = 1'b1;
            end
        end
    end

    // Main sequencer: debounce, cold release, staged release, cause and lock-loss tracking.
    always_ff @(posedge clk_ref) begin
        if (por) begin
            state      <= ST_ASSERT;
            cnt        <= '0;
            idx        <= '0;
            rst_cold_n <= 1'b0;
            rst_done   <= 1'b0;
            rst_cause  <= CAUSE_POR;
            lock_lost  <= 1'b0;
        end else if (full_rst) begin
            // External reset outranks lock loss when both are seen together.
            state      <= ST_ASSERT;
            cnt        <= '0;
            idx        <= '0;
            rst_cold_n <= 1'b0;
            rst_done   <= 1'b0;
            rst_cause  <= ext_hit ? CAUSE_EXT : CAUSE_LOCK;
        end else begin
            // Lock dropped with re-sequencing disabled: flag it and keep running.
            if (lock_hit) begin
                lock_lost <= 1'b1;
            end
            case (state)
                ST_ASSERT: begin
                    rst_cold_n <= 1'b0;
                    rst_done   <= 1'b0;
                    cnt        <= '0;
                    if (rst_ext_n && pll_locked) begin
                        state <= ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    // A glitch here restarts qualification without touching the cause.
                    if (!rst_ext_n || !pll_locked) begin
                        state <= ST_ASSERT;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state <= ST_COLD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_COLD: begin
                    rst_cold_n <= 1'b1;
                    idx        <= '0;
                    cnt        <= '0;
                    state      <= ST_STAGE;
                end
                ST_STAGE: begin
                    if (cnt == STG_LAST) begin
                        cnt <= '0;
                        if (idx == IDX_LAST) begin
                            state <= ST_COMPLETE;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_COMPLETE: begin
                    rst_done <= 1'b1;
                end
                default: begin
                    state <= ST_ASSERT;
                end
            endcase
        end
    end

    // Domain reset outputs: staged release plus independent per-domain software reset handshakes.
    always_ff @(posedge clk_ref) begin
        if (por || full_rst) begin
            rst_dom_n    <= '0;
            soft_rst_ack <= '0;
            for (int i = 0; i < NUM_DOMAINS; i++) begin
                soft_st[i]  <= SS_IDLE;
                hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_DOMAINS; i++) begin
                if (stage_rel[i]) begin
                    rst_dom_n[i] <= 1'b1;
                end
                case (soft_st[i])
                    SS_IDLE: begin
                        // Only a fully sequenced system accepts software resets.
                        if ((state == ST_COMPLETE) && soft_rst_req[i]) begin
                            rst_dom_n[i] <= 1'b0;
                            hold_cnt[i]  <= '0;
                            soft_st[i]   <= SS_HOLD;
                        end
                    end
                    SS_HOLD: begin
                        if (hold_cnt[i] == HOLD_LAST) begin
                            rst_dom_n[i]    <= 1'b1;
                            soft_rst_ack[i] <= 1'b1;
                            soft_st[i]      <= SS_ACK;
                        end else begin
                            hold_cnt[i] <= hold_cnt[i] + HOLD_W'(1);
                        end
                    end
                    SS_ACK: begin
                        if (!soft_rst_req[i]) begin
                            soft_rst_ack[i] <= 1'b0;
                            soft_st[i]      <= SS_IDLE;
                        end
                    end
                    default: begin
                        soft_st[i] <= SS_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Purpose: scenario bench for reset_sequencer with an event scoreboard of expected output changes.
// Latency: every expected change is tagged with the absolute clock edge on which it must occur.
// Backpressure: software requests are driven as levels and dropped only after the ack is seen.
module tb_reset_sequencer;

    localparam int D = 256;
    localparam int S = 16;
    localparam int N = 3;
    localparam int H = 8;

    logic         clk_ref = 1'b0;
    logic         por;
    logic         rst_ext_n;
    logic         pll_locked;
    logic         lock_loss_rst_en;
    logic [N-1:0] soft_rst_req;
    logic [N-1:0] soft_rst_ack;
    logic         rst_cold_n;
    logic [N-1:0] rst_dom_n;
    logic         rst_done;
    logic [1:0]   rst_cause;
    logic         lock_lost;

    always #5 clk_ref = ~clk_ref;

    reset_sequencer #(
        .NUM_DOMAINS      (N),
        .DEBOUNCE_CYCLES  (D),
        .STAGE_CYCLES     (S),
        .SOFT_HOLD_CYCLES (H)
    ) dut (
        .clk_ref          (clk_ref),
        .por              (por),
        .rst_ext_n        (rst_ext_n),
        .pll_locked       (pll_locked),
        .lock_loss_rst_en (lock_loss_rst_en),
        .soft_rst_req     (soft_rst_req),
        .soft_rst_ack     (soft_rst_ack),
        .rst_cold_n       (rst_cold_n),
        .rst_dom_n        (rst_dom_n),
        .rst_done         (rst_done),
        .rst_cause        (rst_cause),
        .lock_lost        (lock_lost)
    );

    typedef struct packed {
        logic         lock_lost;
        logic [1:0]   cause;
        logic [N-1:0] ack;
        logic         done;
        logic [N-1:0] dom;
        logic         cold;
    } obs_t;

    typedef struct packed {
        int   edge_no;
        obs_t val;
    } ev_t;

    ev_t   sb[$];
    string sb_tag[$];
    obs_t  model;
    obs_t  prev_obs;
    obs_t  cur_obs;
    ev_t   mon_e;
    string mon_tag;
    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    bit    mon_en = 1'b0;
    int    e0;
    int    e1;

    assign cur_obs = {lock_lost, rst_cause, soft_rst_ack, rst_done, rst_dom_n, rst_cold_n};

    // Absolute edge counter: after edge k has happened, cyc == k.
    always @(posedge clk_ref) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every observed change of the output bundle consumes one scoreboard entry.
    task automatic monitor();
        if (mon_en && (cur_obs !== prev_obs)) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_change", 32'(cur_obs), 32'(prev_obs));
            end else begin
                mon_e   = sb.pop_front();
                mon_tag = sb_tag.pop_front();
                check_eq({mon_tag, "_edge"}, 32'(cyc), 32'(mon_e.edge_no));
                check_eq({mon_tag, "_value"}, 32'(cur_obs), 32'(mon_e.val));
            end
        end
        prev_obs = cur_obs;
    endtask

    task automatic tick();
        @(negedge clk_ref);
        monitor();
        #1;
    endtask

    task automatic push(input int e, input string tag);
        ev_t ev;
        ev.edge_no = e;
        ev.val     = model;
        sb.push_back(ev);
        sb_tag.push_back(tag);
    endtask

    // Expected release events counted from edge 0 = e0.
    task automatic expect_seq(input int e_zero, input int n_stages, input bit with_done);
        model.cold = 1'b1;
        push(e_zero + D + 1, "cold_rel");
        for (int k = 0; k < n_stages; k++) begin
            model.dom[k] = 1'b1;
            push(e_zero + D + 1 + (k + 1) * S, $sformatf("dom%0d_rel", k));
        end
        if (with_done) begin
            model.done = 1'b1;
            push(e_zero + D + 2 + N * S, "done_rise");
        end
    endtask

    task automatic full_low(input logic [1:0] cause);
        model.cold  = 1'b0;
        model.dom   = '0;
        model.done  = 1'b0;
        model.ack   = '0;
        model.cause = cause;
    endtask

    task automatic drain(input int budget, input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0) && (n < budget)) begin
            tick();
            n++;
        end
        check_eq({tag, "_drained"}, 32'(sb.size()), 32'd0);
        sb.delete();
        sb_tag.delete();
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        por              = 1'b1;
        rst_ext_n        = 1'b0;
        pll_locked       = 1'b0;
        lock_loss_rst_en = 1'b0;
        soft_rst_req     = '0;
        model            = '0;
        repeat (3) tick();
        check_eq("reset_state", 32'(cur_obs), 32'(model));
        prev_obs = cur_obs;
        mon_en   = 1'b1;

        // Power-on sequence with inputs good from edge 0.
        por        = 1'b0;
        rst_ext_n  = 1'b1;
        pll_locked = 1'b1;
        e0 = cyc + 1;
        expect_seq(e0, N, 1'b1);
        drain(D + N * S + 20, "por_seq");
        check_eq("por_cause", 32'(rst_cause), 32'd0);
        repeat (4) tick();

        // Concurrent software resets on domains 0 and 2.
        soft_rst_req = 3'b101;
        e1 = cyc + 1;
        model.dom = 3'b010;
        push(e1, "soft_assert");
        model.dom = 3'b111;
        model.ack = 3'b101;
        push(e1 + H, "soft_release");
        drain(H + 5, "soft");
        repeat (3) tick();
        soft_rst_req = '0;
        model.ack = '0;
        push(cyc + 1, "soft_ack_drop");
        drain(4, "soft_ack");
        check_eq("soft_done_held", 32'(rst_done), 32'd1);

        // Lock loss with re-sequencing disabled: sticky flag only.
        pll_locked = 1'b0;
        model.lock_lost = 1'b1;
        push(cyc + 1, "lock_lost_set");
        drain(4, "lock_lost");
        repeat (3) tick();
        pll_locked = 1'b1;
        repeat (5) tick();
        check_eq("lock_lost_sticky", 32'(lock_lost), 32'd1);
        check_eq("lock_lost_done", 32'(rst_done), 32'd1);

        // Lock loss with re-sequencing enabled.
        lock_loss_rst_en = 1'b1;
        pll_locked = 1'b0;
        full_low(2'b10);
        push(cyc + 1, "lockloss_rst");
        drain(4, "lockloss");
        pll_locked = 1'b1;
        e0 = cyc + 1;
        expect_seq(e0, 1, 1'b0);
        drain(D + S + 20, "relock_partial");

        // External reset for two cycles while stage index is 1.
        run_to(e0 + D + 1 + S + 5);
        rst_ext_n = 1'b0;
        full_low(2'b01);
        push(cyc + 1, "ext_in_stage");
        drain(4, "ext_stage");
        tick();
        rst_ext_n = 1'b1;
        e0 = cyc + 1;
        expect_seq(e0, N, 1'b1);
        drain(D + N * S + 20, "ext_reseq");
        check_eq("ext_cause", 32'(rst_cause), 32'd1);

        // PLL glitch at debounce count 100 restarts the debounce.
        rst_ext_n = 1'b0;
        full_low(2'b01);
        push(cyc + 1, "ext_in_complete");
        drain(4, "ext_complete");
        rst_ext_n = 1'b1;
        e0 = cyc + 1;
        run_to(e0 + 100);
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        e1 = cyc + 1;
        check_eq("glitch_restart_edge", 32'(e1), 32'(e0 + 102));
        expect_seq(e1, N, 1'b1);
        drain(D + N * S + 20, "glitch_reseq");
        check_eq("glitch_cause", 32'(rst_cause), 32'd1);

        // External reset during a domain's hold; held request serviced on COMPLETE entry.
        soft_rst_req = 3'b010;
        e1 = cyc + 1;
        model.dom = 3'b101;
        push(e1, "hold_assert");
        drain(4, "hold");
        run_to(e1 + 3);
        rst_ext_n = 1'b0;
        full_low(2'b01);
        push(cyc + 1, "ext_in_hold");
        drain(4, "ext_hold");
        check_eq("hold_abort_ack", 32'(soft_rst_ack), 32'd0);
        rst_ext_n = 1'b1;
        e0 = cyc + 1;
        expect_seq(e0, N, 1'b0);
        model.done = 1'b1;
        model.dom  = 3'b101;
        push(e0 + D + 2 + N * S, "done_with_held_req");
        model.dom = 3'b111;
        model.ack = 3'b010;
        push(e0 + D + 2 + N * S + H, "held_req_release");
        drain(D + N * S + H + 20, "held_reseq");
        soft_rst_req = '0;
        model.ack = '0;
        push(cyc + 1, "held_ack_drop");
        drain(4, "held_ack");

        repeat (5) tick();
        check_eq("final_outputs", 32'(cur_obs), 32'(model));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
